// File: rtl/sparse_pe_scheduler_if.sv
// -----------------------------------------------------------------------------
// sparse_pe_scheduler_if
//
// Bundles the layer-control, loader handshake and PE issue signals of the
// sparse PE scheduler. The clock and reset stay plain ports on the module.
//
// Signals (direction as seen by the scheduler, i.e. the slave modport):
//   start              in   one-cycle pulse that begins a layer
//   num_in_ch          in   input channel count, sampled on accepted start
//   feature_valid_num  in   nonzero feature count of the presented channel
//   weight_valid_num   in   nonzero weight count of the presented channel
//   load_ack           in   loader data for ch_idx valid this cycle
//   stall              in   downstream accumulator cannot accept products
//   load_req           out  request to the loader for channel ch_idx
//   ch_idx             out  current input channel
//   pe_in_valid        out  PE issue strobe
//   curr_pixel         out  feature group index (4 pixels per group)
//   curr_weight        out  nonzero weight index
//   busy               out  layer in progress
//   done               out  one-cycle layer completion pulse
// -----------------------------------------------------------------------------
interface sparse_pe_scheduler_if #(
  parameter int double_word_length = 16
);
  logic                          start;
  logic [double_word_length-1:0] num_in_ch;
  logic [double_word_length-1:0] feature_valid_num;
  logic [double_word_length-1:0] weight_valid_num;
  logic                          load_ack;
  logic                          stall;
  logic                          load_req;
  logic [double_word_length-1:0] ch_idx;
  logic                          pe_in_valid;
  logic [double_word_length-1:0] curr_pixel;
  logic [double_word_length-1:0] curr_weight;
  logic                          busy;
  logic                          done;

  // Driver side: the layer controller, loader and accumulator.
  modport master (
    output start, num_in_ch, feature_valid_num, weight_valid_num, load_ack, stall,
    input  load_req, ch_idx, pe_in_valid, curr_pixel, curr_weight, busy, done
  );

  // Scheduler side.
  modport slave (
    input  start, num_in_ch, feature_valid_num, weight_valid_num, load_ack, stall,
    output load_req, ch_idx, pe_in_valid, curr_pixel, curr_weight, busy, done
  );
endinterface

// File: rtl/sparse_pe_scheduler.sv
// -----------------------------------------------------------------------------
// sparse_pe_scheduler
//
// Walks one convolution layer channel by channel. For each input channel it
// requests the channel from the loader, latches the nonzero feature/weight
// counts, then issues every (weight, feature-group) pair to the PE array once,
// weight-outer and pixel-group-inner. After the final issue of a channel it
// waits pe_latency cycles for the PE pipeline to empty, then moves on to the
// next channel or finishes the layer with a one-cycle done pulse.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   sparse_pe_scheduler_if.slave (start/count inputs, loader handshake,
//         stall, issue indices, busy/done)
//
// Parameters:
//   double_word_length  width of all counts and indices
//   pe_latency          drain cycles after the last PE issue of a channel
// -----------------------------------------------------------------------------
module sparse_pe_scheduler #(
  parameter int double_word_length = 16,
  parameter int pe_latency         = 2
) (
  input logic                   clk,
  input logic                   rst,
  sparse_pe_scheduler_if.slave  bus
);

  localparam int DW = double_word_length;
  localparam logic [DW-1:0] PE_LAT = DW'(pe_latency);
  localparam logic [DW-1:0] ONE    = DW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q,       state_d;
  logic [DW-1:0]   num_ch_q,      num_ch_d;
  logic [DW-1:0]   ch_idx_q,      ch_idx_d;
  logic [DW-1:0]   groups_q,      groups_d;
  logic [DW-1:0]   weights_q,     weights_d;
  logic [DW-1:0]   pixel_q,       pixel_d;
  logic [DW-1:0]   weight_idx_q,  weight_idx_d;
  logic [DW-1:0]   drain_q,       drain_d;
  logic            load_req_q,    load_req_d;
  logic            busy_q,        busy_d;
  logic            done_q,        done_d;

  // ---------------------------------------------------------------------------
  // Helper arithmetic
  // ---------------------------------------------------------------------------
  // Group count is ceil(features / 4). The sum carries one extra bit so an
  // all-ones feature count rounds up instead of wrapping to zero groups.
  logic [DW:0]   feat_sum;
  logic [DW-1:0] groups_calc;
  assign feat_sum    = {1'b0, bus.feature_valid_num} + (DW+1)'(3);
  assign groups_calc = DW'(feat_sum >> 2);

  // Channel advance: compared one bit wider so ch_idx+1 cannot wrap.
  logic [DW:0]   ch_next;
  logic          last_ch;
  state_e        adv_state;
  logic [DW-1:0] adv_ch;
  assign ch_next   = {1'b0, ch_idx_q} + (DW+1)'(1);
  assign last_ch   = (ch_next >= {1'b0, num_ch_q});
  assign adv_state = last_ch ? ST_DONE : ST_LOAD;
  assign adv_ch    = last_ch ? ch_idx_q : (ch_idx_q + ONE);

  logic last_pixel;
  logic last_weight;
  assign last_pixel  = (pixel_q == groups_q - ONE);
  assign last_weight = (weight_idx_q == weights_q - ONE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    num_ch_d     = num_ch_q;
    ch_idx_d     = ch_idx_q;
    groups_d     = groups_q;
    weights_d    = weights_q;
    pixel_d      = pixel_q;
    weight_idx_d = weight_idx_q;
    drain_d      = drain_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          num_ch_d = bus.num_in_ch;
          ch_idx_d = '0;
          state_d  = (bus.num_in_ch != '0) ? ST_LOAD : ST_DONE;
        end
      end

      ST_LOAD: begin
        if (bus.load_ack) begin
          groups_d     = groups_calc;
          weights_d    = bus.weight_valid_num;
          pixel_d      = '0;
          weight_idx_d = '0;
          if ((groups_calc != '0) && (bus.weight_valid_num != '0)) begin
            state_d = ST_RUN;
          end else begin
            // Empty channel: skip straight to the next one with no issue.
            state_d  = adv_state;
            ch_idx_d = adv_ch;
          end
        end
      end

      ST_RUN: begin
        if (!bus.stall) begin
          if (last_pixel) begin
            if (last_weight) begin
              // Final pair issued: indices stay on their last values.
              state_d = ST_DRAIN;
              drain_d = PE_LAT;
            end else begin
              pixel_d      = '0;
              weight_idx_d = weight_idx_q + ONE;
            end
          end else begin
            pixel_d = pixel_q + ONE;
          end
        end
      end

      ST_DRAIN: begin
        // Counts down regardless of stall; a zero latency still spends one
        // cycle here.
        drain_d = (drain_q == '0) ? '0 : (drain_q - ONE);
        if (drain_q <= ONE) begin
          state_d  = adv_state;
          ch_idx_d = adv_ch;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned
  // with the state they describe.
  always_comb begin
    load_req_d = (state_d == ST_LOAD);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d     = (state_d == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      num_ch_q     <= '0;
      ch_idx_q     <= '0;
      groups_q     <= '0;
      weights_q    <= '0;
      pixel_q      <= '0;
      weight_idx_q <= '0;
      drain_q      <= '0;
      load_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_ch_q     <= num_ch_d;
      ch_idx_q     <= ch_idx_d;
      groups_q     <= groups_d;
      weights_q    <= weights_d;
      pixel_q      <= pixel_d;
      weight_idx_q <= weight_idx_d;
      drain_q      <= drain_d;
      load_req_q   <= load_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.load_req    = load_req_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ch_idx      = ch_idx_q;
  assign bus.curr_pixel  = pixel_q;
  assign bus.curr_weight = weight_idx_q;
  // The issue strobe reacts to stall in the same cycle so no product is
  // offered while the accumulator is blocked.
  assign bus.pe_in_valid = (state_q == ST_RUN) && !bus.stall;

endmodule

// File: tb/tb_sparse_pe_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sparse_pe_scheduler
//
// Directed and randomized layers against a reference model that expands each
// layer into the ordered list of channel loads and (channel, weight, group)
// issues, plus the expected cycle of the done pulse.
// -----------------------------------------------------------------------------
module tb_sparse_pe_scheduler;

  localparam int DW     = 16;
  localparam int PE_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sparse_pe_scheduler_if #(.double_word_length(DW)) bus ();

  sparse_pe_scheduler #(
    .double_word_length (DW),
    .pe_latency         (PE_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [DW-1:0] ch;
    logic [DW-1:0] w;
    logic [DW-1:0] p;
  } issue_t;

  logic [DW-1:0] ch_feat [8];
  logic [DW-1:0] ch_wt   [8];
  issue_t        exp_q   [$];
  int            load_q  [$];

  int n_vec;
  int n_err;
  bit seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int groups_of(input logic [DW-1:0] f);
    return (int'(f) + 3) / 4;
  endfunction

  // Runs one layer of nch channels (counts taken from ch_feat/ch_wt).
  // Entered and left just after a rising edge with the DUT idle.
  task automatic run_layer(input int nch, input int stall_pct, input bit noise,
                           input int stall_from, input int stall_len, input int ack_dly);
    int  cyc, last_issue, last_ack, ack_cyc, run_idx, exp_done;
    bit  done_seen, ack_now;

    exp_q.delete();
    load_q.delete();
    for (int c = 0; c < nch; c++) begin
      load_q.push_back(c);
      for (int w = 0; w < int'(ch_wt[c]); w++)
        for (int p = 0; p < groups_of(ch_feat[c]); p++)
          exp_q.push_back('{ch: DW'(c), w: DW'(w), p: DW'(p)});
    end

    cyc = 0; last_issue = -1; last_ack = -1; ack_cyc = -1000; done_seen = 0;
    while (!done_seen && cyc < 60000) begin
      // ---- drive this cycle's inputs
      if (cyc == 0) begin
        bus.start     = 1'b1;
        bus.num_in_ch = DW'(nch);
        bus.load_ack  = 1'b0;
        bus.stall     = 1'b0;
      end else begin
        bus.start     = noise && bus.busy && ($urandom_range(0, 9) == 0);
        bus.num_in_ch = DW'($urandom);
        ack_now = bus.load_req && (load_q.size() > 0) &&
                  ((ack_dly == 0) || ($urandom_range(0, ack_dly) == 0));
        if (ack_now) begin
          bus.feature_valid_num = ch_feat[load_q[0]];
          bus.weight_valid_num  = ch_wt[load_q[0]];
        end else begin
          bus.feature_valid_num = DW'($urandom);
          bus.weight_valid_num  = DW'($urandom);
        end
        bus.load_ack = ack_now || (noise && !bus.load_req && ($urandom_range(0, 3) == 0));
        run_idx   = cyc - ack_cyc - 1;
        bus.stall = ($urandom_range(0, 99) < stall_pct) ||
                    ((stall_len > 0) && (run_idx >= stall_from) && (run_idx < stall_from + stall_len));
      end

      // ---- observe away from the edge
      @(negedge clk);
      if (load_q.size() == 0) begin
        check("spurious_load_req", bus.load_req, 1'b0);
      end else if (bus.load_req) begin
        check("load_ch", bus.ch_idx, load_q[0]);
        check("load_busy", bus.busy, 1'b1);
        if (bus.load_ack) begin
          last_ack = cyc;
          ack_cyc  = cyc;
          void'(load_q.pop_front());
        end
      end

      if (exp_q.size() > 0 && bus.busy && !bus.load_req && bus.ch_idx == exp_q[0].ch) begin
        check("pixel_idx", bus.curr_pixel, exp_q[0].p);
        check("weight_idx", bus.curr_weight, exp_q[0].w);
        check("issue_valid", bus.pe_in_valid, !bus.stall);
        if (bus.pe_in_valid) begin
          void'(exp_q.pop_front());
          last_issue = cyc;
        end
      end else begin
        check("no_issue", bus.pe_in_valid, 1'b0);
      end

      if (bus.done) begin
        done_seen = 1;
        if (nch == 0)
          exp_done = 1;
        else if (groups_of(ch_feat[nch-1]) > 0 && ch_wt[nch-1] != '0)
          exp_done = last_issue + PE_LAT + 1;
        else
          exp_done = last_ack + 1;
        check("done_busy", bus.busy, 1'b0);
        check("issues_left", exp_q.size(), 0);
        check("loads_left", load_q.size(), 0);
        check("done_cycle", cyc, exp_done);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("done_timeout", done_seen, 1'b1);

    bus.start    = 1'b0;
    bus.load_ack = 1'b0;
    bus.stall    = 1'b0;
    @(negedge clk);
    check("done_one_cycle", bus.done, 1'b0);
    check("idle_busy", bus.busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst                   = 1'b1;
    bus.start             = 1'b0;
    bus.num_in_ch         = '0;
    bus.feature_valid_num = '0;
    bus.weight_valid_num  = '0;
    bus.load_ack          = 1'b0;
    bus.stall             = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_load_req", bus.load_req, 1'b0);
    check("rst_valid", bus.pe_in_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ch_idx", bus.ch_idx, 0);
    check("rst_pixel", bus.curr_pixel, 0);
    check("rst_weight", bus.curr_weight, 0);
    @(posedge clk);
    #1;

    // One channel, 2 groups x 3 weights, no stall
    ch_feat[0] = 8; ch_wt[0] = 3;
    run_layer(1, 0, 0, 0, 0, 0);

    // Stall on the second RUN cycle for three cycles
    ch_feat[0] = 5; ch_wt[0] = 1;
    run_layer(1, 0, 0, 1, 3, 0);

    // Middle channel has no weights
    ch_feat[0] = 6; ch_wt[0] = 2;
    ch_feat[1] = 9; ch_wt[1] = 0;
    ch_feat[2] = 3; ch_wt[2] = 2;
    run_layer(3, 0, 0, 0, 0, 2);

    // Zero-channel layer
    run_layer(0, 0, 0, 0, 0, 0);

    // Stray start / load_ack during the layer
    ch_feat[0] = 7; ch_wt[0] = 2;
    ch_feat[1] = 4; ch_wt[1] = 3;
    run_layer(2, 20, 1, 0, 0, 1);

    // Group-count boundaries, including an empty last channel
    ch_feat[0] = 1; ch_wt[0] = 1;
    ch_feat[1] = 4; ch_wt[1] = 2;
    ch_feat[2] = 5; ch_wt[2] = 1;
    ch_feat[3] = 0; ch_wt[3] = 3;
    run_layer(4, 10, 0, 0, 0, 1);

    // All-ones feature count must round up, not wrap
    ch_feat[0] = 16'hFFFF; ch_wt[0] = 1;
    run_layer(1, 0, 0, 0, 0, 0);

    // Randomized layers
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 4; c++) begin
        ch_feat[c] = DW'($urandom_range(0, 13));
        ch_wt[c]   = DW'($urandom_range(0, 4));
      end
      run_layer(int'($urandom_range(1, 4)), 25, 1, 0, 0, 3);
    end

    // Asynchronous reset while issuing channel 1 at weight index 1
    ch_feat[0] = 4; ch_wt[0] = 1;
    ch_feat[1] = 8; ch_wt[1] = 3;
    bus.num_in_ch = 2;
    bus.start     = 1'b1;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.pe_in_valid && bus.ch_idx == 1 && bus.curr_weight == 1) begin
        seen = 1;
      end else begin
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.load_ack = bus.load_req;
        if (bus.load_req) begin
          bus.feature_valid_num = ch_feat[bus.ch_idx[2:0]];
          bus.weight_valid_num  = ch_wt[bus.ch_idx[2:0]];
        end
      end
    end
    check("rst_reach_run", seen, 1'b1);
    bus.load_ack = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", bus.pe_in_valid, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_load_req", bus.load_req, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_ch_idx", bus.ch_idx, 0);
    check("arst_pixel", bus.curr_pixel, 0);
    check("arst_weight", bus.curr_weight, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_done", bus.done, 1'b0);
      check("post_rst_idle", bus.busy, 1'b0);
      @(posedge clk);
      #1;
    end
    run_layer(2, 10, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
